addrc_issuer: RTL and testbench
===============================

# addrc_issuer

Initiator for the add-round-constant stage's start/ready handshake. On a single `go` request it runs a fixed number of rounds. For each round it raises `start`, waits for the round-constant controller to complete one ld cycle, then advances a round index that the datapath uses to select the round constant. It sits between the top-level encoder sequencer and the addrc control unit, and reports `busy` and a one-cycle `done` upward.

## Interface
- `ROUNDS`, 24: number of rounds per request; must be ≥ 1.
- `RW`, 5: width of the round index; must satisfy 2^RW ≥ `ROUNDS`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `go` input 1: request to run `ROUNDS` rounds; sampled only in IDLE.
- `abort` input 1: cancels the run in progress; no `done` is produced.
- `ready` input 1: from the addrc controller; high while it is idle and able to accept `start`.
- `start` output 1: request to the addrc controller; held until it is sampled with `ready`=1.
- `round` output RW: index of the current round, 0..`ROUNDS`-1; registered.
- `round_last` output 1: high when `round` == `ROUNDS`-1 and `busy`=1.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last round completes.

## Operation
- States:
  - IDLE: `busy`=0.
  - ISSUE: `start`=1.
  - WAIT_LOW: waiting for `ready` to fall.
  - WAIT_HIGH: waiting for `ready` to return.
  - FINISH: `done`=1.
- All outputs are Moore-decoded from state and registers; no combinational path from inputs to outputs.
- Transitions:
  - IDLE: if `go`=1, `round`←0, go to ISSUE; otherwise stay.
  - ISSUE: if `ready`=1, go to WAIT_LOW (the handshake is accepted this cycle). If `ready`=0, stay with `start` held high.
  - WAIT_LOW: if `ready`=0, go to WAIT_HIGH; otherwise stay.
  - WAIT_HIGH: if `ready`=1 and `round`==`ROUNDS`-1, go to FINISH. If `ready`=1 otherwise, `round`←`round`+1 and go to ISSUE. If `ready`=0, stay.
  - FINISH: go to IDLE unconditionally.
- `abort`=1 in any non-IDLE state: next state is IDLE and `round`←0. `abort` takes priority over all other transitions and is ignored in IDLE.
- Undefined state encodings recover to IDLE.
- `round` increments without wrap; it is only cleared in IDLE→ISSUE, by `abort`, and by `rst`.
- `go` while `busy`=1 is ignored, not queued.
- Simultaneous `go` and `abort` in IDLE: the run starts.

## Timing
- Reset values: `start`=0, `busy`=0, `done`=0, `round`=0, `round_last`=0, state IDLE.
- `rst`=1 mid-run: IDLE on the next edge; `start` drops that cycle; no `done`.
- With a responder that drops `ready` for exactly two cycles after accepting, the schedule is (`go` sampled at the end of cycle 0):
  - cycle 1: ISSUE, `start`=1.
  - cycle 2: WAIT_LOW.
  - cycle 3: WAIT_HIGH.
  - cycle 4: `ready` returns.
  - cycle 5: ISSUE with `round`=1.
- Round period is 4 cycles. ISSUE for round k occurs at cycle 4k+1.
- Last round is accepted at 4·`ROUNDS`-3; `done` is high at cycle 4·`ROUNDS`+1. For `ROUNDS`=24, `done` is at cycle 97 and IDLE at cycle 98.
- A new `go` can be accepted in cycle 98, giving the next ISSUE at cycle 99.
- `start` is high for exactly one cycle per round when `ready` is high on entry to ISSUE. It stays high for N+1 cycles if `ready` is low for N cycles.
- `ROUNDS`=1: ISSUE at cycle 1, `done` at cycle 5, `round_last`=1 for cycles 1–5.

## Test plan
- Reset, then `go` pulse at cycle 0, responder is a behavioural addrc controller, `ROUNDS`=24 → `start` high at cycles 1,5,…,93; `round` steps 0..23; `done` only at cycle 97; `busy` high in cycles 1–97.
- Responder holds `ready`=0 for 3 cycles before the round-2 ISSUE → `start` is held 4 cycles, `round` stays 2, and the round completes after `ready` rises. No round is skipped or duplicated.
- `abort` asserted in WAIT_HIGH of round 5 → IDLE next cycle, `round`=0, `busy`=0, no `done`. A following `go` restarts from round 0.
- `go` re-pulsed at cycles 10 and 50 during a run → ignored; exactly 24 `start` handshakes and one `done`.
- `rst` asserted during round 7 ISSUE → next cycle all outputs are at reset values. A subsequent `go` completes a clean 24-round run.
- `ROUNDS`=1, `RW`=1 → single handshake, `done` at cycle 5, `round_last` high cycles 1–5.

Source files
------------

// File: rtl/addrc_issuer.sv
// addrc_issuer: issues ROUNDS start/ready handshakes to the add-round-constant
// controller per go request. It steps a round index for the datapath and
// reports busy and a one-cycle done pulse to the encoder sequencer.
module addrc_issuer #(
    parameter int ROUNDS = 24,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          abort,
    input  logic          ready,
    output logic          start,
    output logic [RW-1:0] round,
    output logic          round_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        FINISH    = 3'd4
    } state_t;

    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    state_t        state, nxt_state;
    logic [RW-1:0] nxt_round;

    // Next-state and next-round decode; abort overrides every busy-state move
    always_comb begin
        nxt_state = state;
        nxt_round = round;
        case (state)
            IDLE: begin
                if (go) begin
                    nxt_state = ISSUE;
                    nxt_round = '0;
                end
            end
            ISSUE: begin
                // Handshake accepted when the controller is ready while start is up
                if (ready) nxt_state = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!ready) nxt_state = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (ready) begin
                    if (round == LAST) begin
                        nxt_state = FINISH;
                    end else begin
                        nxt_state = ISSUE;
                        nxt_round = round + RW'(1);
                    end
                end
            end
            FINISH: begin
                nxt_state = IDLE;
            end
            default: begin
                // Unused encodings fall back to a clean idle
                nxt_state = IDLE;
                nxt_round = '0;
            end
        endcase
        if (abort && state != IDLE) begin
            nxt_state = IDLE;
            nxt_round = '0;
        end
    end

    // State, round index and Moore outputs, all registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            round      <= '0;
            start      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            round_last <= 1'b0;
        end else begin
            state      <= nxt_state;
            round      <= nxt_round;
            start      <= (nxt_state == ISSUE);
            busy       <= (nxt_state != IDLE);
            done       <= (nxt_state == FINISH);
            round_last <= (nxt_state != IDLE) && (nxt_round == LAST);
        end
    end

endmodule

// File: tb/tb_addrc_issuer.sv
// Bench for addrc_issuer: a 24-round instance and a single-round instance,
// each driven by a behavioural addrc controller that drops ready for two
// cycles after every accepted start.
module tb_addrc_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       go1, abort1, go2, abort2;
    logic       ready1, ready2;
    logic       start1, last1, busy1, done1;
    logic       start2, last2, busy2, done2;
    logic [4:0] round1;
    logic [0:0] round2;

    int  checks   = 0;
    int  failures = 0;
    int  rel      = 0;
    bit  stall_en = 0;
    logic [1:0] lo1, lo2;

    always #5 clk = ~clk;

    addrc_issuer #(.ROUNDS(24), .RW(5)) dut1 (
        .clk(clk), .rst(rst), .go(go1), .abort(abort1), .ready(ready1),
        .start(start1), .round(round1), .round_last(last1), .busy(busy1), .done(done1)
    );

    addrc_issuer #(.ROUNDS(1), .RW(1)) dut2 (
        .clk(clk), .rst(rst), .go(go2), .abort(abort2), .ready(ready2),
        .start(start2), .round(round2), .round_last(last2), .busy(busy2), .done(done2)
    );

    // Behavioural controllers; dut1's can be stalled for cycles 9..11 of a run
    assign ready1 = (lo1 == 2'd0) && !(stall_en && rel >= 9 && rel <= 11);
    assign ready2 = (lo2 == 2'd0);

    always @(posedge clk) begin
        if (rst) lo1 <= 2'd0;
        else if (start1 && ready1) lo1 <= 2'd2;
        else if (lo1 != 2'd0) lo1 <= lo1 - 2'd1;
    end

    always @(posedge clk) begin
        if (rst) lo2 <= 2'd0;
        else if (start2 && ready2) lo2 <= 2'd2;
        else if (lo2 != 2'd0) lo2 <= lo2 - 2'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, rel);
        end
    endtask

    // One full dut1 run from a go at cycle 0; counts handshakes and done pulses
    task automatic run24(input bit stall, input bit repulse, input int done_exp);
        int hs = 0, dones = 0, done_at = -1;
        stall_en = stall;
        @(negedge clk); rel = 0; go1 = 1'b1;
        for (int c = 1; c <= done_exp + 3; c++) begin
            @(negedge clk); rel = c;
            go1 = repulse && (c == 10 || c == 50);
            if (start1 && ready1) begin
                chk("hs_round", int'(round1), hs);
                hs++;
            end
            if (done1) begin
                dones++;
                done_at = c;
            end
            if (stall && c >= 9 && c <= 13) begin
                chk("stall_start", int'(start1), (c <= 12) ? 1 : 0);
                chk("stall_round", int'(round1), 2);
            end
        end
        go1 = 1'b0;
        stall_en = 0;
        chk("run_handshakes", hs, 24);
        chk("run_dones", dones, 1);
        chk("run_done_cycle", done_at, done_exp);
        chk("run_idle_busy", int'(busy1), 0);
    endtask

    typedef struct {
        int   cyc;
        logic start;
        logic busy;
        logic done;
        int   round;
        logic last;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    initial begin
        int hs, dones, done_at;
        tbl[0]  = '{1,  1'b1, 1'b1, 1'b0, 0,  1'b0};
        tbl[1]  = '{2,  1'b0, 1'b1, 1'b0, 0,  1'b0};
        tbl[2]  = '{3,  1'b0, 1'b1, 1'b0, 0,  1'b0};
        tbl[3]  = '{4,  1'b0, 1'b1, 1'b0, 0,  1'b0};
        tbl[4]  = '{5,  1'b1, 1'b1, 1'b0, 1,  1'b0};
        tbl[5]  = '{9,  1'b1, 1'b1, 1'b0, 2,  1'b0};
        tbl[6]  = '{89, 1'b1, 1'b1, 1'b0, 22, 1'b0};
        tbl[7]  = '{92, 1'b0, 1'b1, 1'b0, 22, 1'b0};
        tbl[8]  = '{93, 1'b1, 1'b1, 1'b0, 23, 1'b1};
        tbl[9]  = '{96, 1'b0, 1'b1, 1'b0, 23, 1'b1};
        tbl[10] = '{97, 1'b0, 1'b1, 1'b1, 23, 1'b1};
        tbl[11] = '{98, 1'b0, 1'b0, 1'b0, 23, 1'b0};

        rst = 1'b1; go1 = 1'b0; abort1 = 1'b0; go2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", int'(start1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_round", int'(round1), 0);
        chk("rst_last", int'(last1), 0);
        rst = 1'b0;

        // Nominal 24-round run, then a back-to-back go accepted at cycle 98
        hs = 0; dones = 0; done_at = -1;
        @(negedge clk); rel = 0; go1 = 1'b1;
        for (int c = 1; c <= 98; c++) begin
            @(negedge clk); rel = c;
            if (c == 1) go1 = 1'b0;
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].cyc == c) begin
                    chk("vec_start", int'(start1), int'(tbl[i].start));
                    chk("vec_busy", int'(busy1), int'(tbl[i].busy));
                    chk("vec_done", int'(done1), int'(tbl[i].done));
                    chk("vec_round", int'(round1), tbl[i].round);
                    chk("vec_last", int'(last1), int'(tbl[i].last));
                end
            end
            chk("nom_busy", int'(busy1), (c <= 97) ? 1 : 0);
            chk("nom_start", int'(start1), (c <= 93 && (c % 4) == 1) ? 1 : 0);
            if (start1 && ready1) begin
                chk("nom_hs_round", int'(round1), hs);
                hs++;
            end
            if (done1) begin
                dones++;
                done_at = c;
            end
        end
        chk("nom_handshakes", hs, 24);
        chk("nom_dones", dones, 1);
        chk("nom_done_cycle", done_at, 97);
        go1 = 1'b1;

        // Second run starts at 99; abort it in round 5 WAIT_HIGH (cycle 121)
        for (int c = 99; c <= 126; c++) begin
            @(negedge clk); rel = c - 98;
            if (c == 99) begin
                go1 = 1'b0;
                chk("b2b_start", int'(start1), 1);
                chk("b2b_round", int'(round1), 0);
            end
            if (c == 121) begin
                chk("pre_abort_round", int'(round1), 5);
                chk("pre_abort_start", int'(start1), 0);
                abort1 = 1'b1;
            end
            if (c == 122) begin
                abort1 = 1'b0;
                chk("abort_busy", int'(busy1), 0);
                chk("abort_round", int'(round1), 0);
                chk("abort_start", int'(start1), 0);
                chk("abort_last", int'(last1), 0);
            end
            if (c >= 122) chk("abort_no_done", int'(done1), 0);
        end

        // Restart after abort: stalled round 2 plus ignored go pulses at 10 and 50
        run24(1'b1, 1'b1, 100);

        // Reset during round 7 ISSUE, then a clean full run
        @(negedge clk); rel = 0; go1 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk); rel = c;
            if (c == 1) go1 = 1'b0;
            if (c == 29) begin
                chk("r7_start", int'(start1), 1);
                chk("r7_round", int'(round1), 7);
                rst = 1'b1;
            end
            if (c == 30) begin
                rst = 1'b0;
                chk("mrst_start", int'(start1), 0);
                chk("mrst_busy", int'(busy1), 0);
                chk("mrst_done", int'(done1), 0);
                chk("mrst_round", int'(round1), 0);
                chk("mrst_last", int'(last1), 0);
            end
        end
        run24(1'b0, 1'b0, 97);

        // Single-round instance
        hs = 0;
        @(negedge clk); rel = 0; go2 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); rel = c;
            if (c == 1) go2 = 1'b0;
            chk("r1_start", int'(start2), (c == 1) ? 1 : 0);
            chk("r1_done", int'(done2), (c == 5) ? 1 : 0);
            chk("r1_last", int'(last2), (c <= 5) ? 1 : 0);
            chk("r1_busy", int'(busy2), (c <= 5) ? 1 : 0);
            chk("r1_round", int'(round2), 0);
            if (start2 && ready2) hs++;
        end
        chk("r1_handshakes", hs, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
